// File: rtl/bsg_bp_mem_word_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bsg_bp_mem_word_serializer_pkg
// Purpose  : Shared types and helpers for the wide-to-word memory serializer.
// Revision : 1.0 - initial release
// ============================================================================
package bsg_bp_mem_word_serializer_pkg;

  // Transaction sequencing states
  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_send = 2'd1,
    e_resp = 2'd2
  } state_e;

  // log2 of the downstream word size in bytes
  function automatic int word_size_f(input int word_width);
    return $clog2(word_width / 8);
  endfunction

  // Number of downstream beats needed for a request of 2^size bytes.
  // Anything that fits in one word (including sub-word accesses) is one beat.
  function automatic logic [31:0] beats_f(input logic [2:0] size, input logic [31:0] word_bytes);
    logic [31:0] bytes;
    bytes = 32'd1 << size;
    if (bytes <= word_bytes) beats_f = 32'd1;
    else                     beats_f = bytes / word_bytes;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_bp_mem_word_gather.sv
`default_nettype none
// ============================================================================
// Module   : bsg_bp_mem_word_gather
// Purpose  : Word-indexed block buffer; each slot loads independently and the
//            whole block can be cleared in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_bp_mem_word_gather #(
  parameter int block_width_p = 512,
  parameter int word_width_p  = 32,
  parameter int idx_w_p       = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     i_clear,
  input  logic                     i_we,
  input  logic [idx_w_p-1:0]       i_idx,
  input  logic [word_width_p-1:0]  i_data,
  output logic [block_width_p-1:0] o_data
);

  localparam int words_lp = block_width_p / word_width_p;

  logic [word_width_p-1:0] r_slot [words_lp];

  for (genvar i = 0; i < words_lp; i++) begin : g_slot
    // Slot i: cleared at the start of a transaction, loaded when its index is written
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_slot[i] <= '0;
      end else if (i_clear) begin
        r_slot[i] <= '0;
      end else if (i_we && (i_idx == idx_w_p'(i))) begin
        r_slot[i] <= i_data;
      end
    end

    assign o_data[i*word_width_p +: word_width_p] = r_slot[i];
  end

endmodule
`default_nettype wire

// File: rtl/bsg_bp_mem_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bsg_bp_mem_word_serializer
// Purpose  : Splits one wide memory command into word commands and gathers the
//            in-order word responses back into one wide response.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_bp_mem_word_serializer
  import bsg_bp_mem_word_serializer_pkg::*;
#(
  parameter int paddr_width_p   = 40,
  parameter int block_width_p   = 512,
  parameter int word_width_p    = 32,
  parameter int payload_width_p = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,

  input  logic                       wide_cmd_write_i,
  input  logic [paddr_width_p-1:0]   wide_cmd_addr_i,
  input  logic [2:0]                 wide_cmd_size_i,
  input  logic [payload_width_p-1:0] wide_cmd_payload_i,
  input  logic [block_width_p-1:0]   wide_cmd_data_i,
  input  logic                       wide_cmd_v_i,
  output logic                       wide_cmd_ready_o,

  output logic                       wide_resp_write_o,
  output logic [paddr_width_p-1:0]   wide_resp_addr_o,
  output logic [2:0]                 wide_resp_size_o,
  output logic [payload_width_p-1:0] wide_resp_payload_o,
  output logic [block_width_p-1:0]   wide_resp_data_o,
  output logic                       wide_resp_v_o,
  input  logic                       wide_resp_yumi_i,

  output logic                       word_cmd_write_o,
  output logic [paddr_width_p-1:0]   word_cmd_addr_o,
  output logic [2:0]                 word_cmd_size_o,
  output logic [payload_width_p-1:0] word_cmd_payload_o,
  output logic [word_width_p-1:0]    word_cmd_data_o,
  output logic                       word_cmd_v_o,
  input  logic                       word_cmd_ready_i,

  input  logic [word_width_p-1:0]    word_resp_data_i,
  input  logic                       word_resp_v_i,
  output logic                       word_resp_yumi_o
);

  localparam int words_lp      = block_width_p / word_width_p;
  localparam int word_bytes_lp = word_width_p / 8;
  localparam int word_size_lp  = word_size_f(word_width_p);
  localparam int cnt_w_lp      = $clog2(words_lp + 1);
  localparam int idx_w_lp      = (words_lp > 1) ? $clog2(words_lp) : 1;
  localparam int max_size_lp   = $clog2(block_width_p / 8);

  state_e                     r_state, w_state_n;
  logic                       r_write;
  logic [paddr_width_p-1:0]   r_addr;
  logic [2:0]                 r_size;
  logic [payload_width_p-1:0] r_payload;
  logic [block_width_p-1:0]   r_data;
  logic [cnt_w_lp-1:0]        r_n, r_sent, r_rcvd;

  logic                       w_accept, w_cmd_fire, w_resp_take, w_last_resp;
  logic [cnt_w_lp-1:0]        w_beats, w_rcvd_inc;
  logic [idx_w_lp-1:0]        w_sent_idx, w_rcvd_idx;

  // Ready is forced low while reset is held so nothing is accepted during reset
  assign wide_cmd_ready_o = reset_n_i & (r_state == e_idle);
  assign w_accept         = wide_cmd_v_i & wide_cmd_ready_o;
  assign word_cmd_v_o     = (r_state == e_send) & (r_sent < r_n);
  assign w_cmd_fire       = word_cmd_v_o & word_cmd_ready_i;
  // A response is only taken for a command whose handshake has already completed
  assign word_resp_yumi_o = (r_state == e_send) & word_resp_v_i & (r_rcvd < r_sent);
  assign w_resp_take      = word_resp_yumi_o;
  assign w_rcvd_inc       = r_rcvd + cnt_w_lp'(1);
  assign w_last_resp      = w_resp_take & (w_rcvd_inc == r_n);
  assign w_beats          = cnt_w_lp'(beats_f(wide_cmd_size_i, 32'(word_bytes_lp)));

  // Counter values index word slots; a fully sent block wraps the slot index to 0,
  // which is harmless because no command is presented then
  assign w_sent_idx = r_sent[idx_w_lp-1:0];
  assign w_rcvd_idx = r_rcvd[idx_w_lp-1:0];

  // Word command fields depend only on registers, so they hold steady under stall
  assign word_cmd_write_o   = r_write;
  assign word_cmd_addr_o    = r_addr + (paddr_width_p'(r_sent) << word_size_lp);
  assign word_cmd_size_o    = (r_size < 3'(word_size_lp)) ? r_size : 3'(word_size_lp);
  assign word_cmd_payload_o = r_payload;
  assign word_cmd_data_o    = r_data[w_sent_idx*word_width_p +: word_width_p];

  assign wide_resp_write_o   = r_write;
  assign wide_resp_addr_o    = r_addr;
  assign wide_resp_size_o    = r_size;
  assign wide_resp_payload_o = r_payload;
  assign wide_resp_v_o       = (r_state == e_resp);

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= e_idle;
    else            r_state <= w_state_n;
  end

  // Next-state logic: one wide transaction at a time, one bubble after the response
  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      e_idle:  if (w_accept)         w_state_n = e_send;
      e_send:  if (w_last_resp)      w_state_n = e_resp;
      e_resp:  if (wide_resp_yumi_i) w_state_n = e_idle;
      default:                       w_state_n = e_idle;
    endcase
  end

  // Latch the wide command header and write data on acceptance
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_size    <= '0;
      r_payload <= '0;
      r_data    <= '0;
    end else if (w_accept) begin
      r_write   <= wide_cmd_write_i;
      r_addr    <= wide_cmd_addr_i;
      r_size    <= wide_cmd_size_i;
      r_payload <= wide_cmd_payload_i;
      r_data    <= wide_cmd_data_i;
    end
  end

  // Beat count plus sent/received progress counters
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_n    <= '0;
      r_sent <= '0;
      r_rcvd <= '0;
    end else if (w_accept) begin
      r_n    <= w_beats;
      r_sent <= '0;
      r_rcvd <= '0;
    end else begin
      if (w_cmd_fire)  r_sent <= r_sent + cnt_w_lp'(1);
      if (w_resp_take) r_rcvd <= w_rcvd_inc;
    end
  end

  // Read responses land in their word slot; write acknowledgements carry no data
  bsg_bp_mem_word_gather #(
    .block_width_p (block_width_p),
    .word_width_p  (word_width_p),
    .idx_w_p       (idx_w_lp)
  ) u_gather (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .i_clear   (w_accept),
    .i_we      (w_resp_take & ~r_write),
    .i_idx     (w_rcvd_idx),
    .i_data    (word_resp_data_i),
    .o_data    (wide_resp_data_o)
  );

`ifndef SYNTHESIS
  // Protocol checks on both handshake interfaces
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(w_accept && (wide_cmd_size_i > 3'(max_size_lp))));
      assert (!(word_resp_v_i && (r_rcvd == r_sent)));
      assert (!(wide_resp_yumi_i && !wide_resp_v_o));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_bp_mem_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_bp_mem_word_serializer
// Purpose  : Self-checking bench for the wide-to-word memory serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_bp_mem_word_serializer;

  logic         clk;
  logic         reset_n;
  logic         wide_cmd_write_i;
  logic [39:0]  wide_cmd_addr_i;
  logic [2:0]   wide_cmd_size_i;
  logic [31:0]  wide_cmd_payload_i;
  logic [511:0] wide_cmd_data_i;
  logic         wide_cmd_v_i;
  logic         wide_cmd_ready_o;
  logic         wide_resp_write_o;
  logic [39:0]  wide_resp_addr_o;
  logic [2:0]   wide_resp_size_o;
  logic [31:0]  wide_resp_payload_o;
  logic [511:0] wide_resp_data_o;
  logic         wide_resp_v_o;
  logic         wide_resp_yumi_i;
  logic         word_cmd_write_o;
  logic [39:0]  word_cmd_addr_o;
  logic [2:0]   word_cmd_size_o;
  logic [31:0]  word_cmd_payload_o;
  logic [31:0]  word_cmd_data_o;
  logic         word_cmd_v_o;
  logic         word_cmd_ready_i;
  logic [31:0]  word_resp_data_i;
  logic         word_resp_v_i;
  logic         word_resp_yumi_o;

  bsg_bp_mem_word_serializer dut (
    .clk_i               (clk),
    .reset_n_i           (reset_n),
    .wide_cmd_write_i    (wide_cmd_write_i),
    .wide_cmd_addr_i     (wide_cmd_addr_i),
    .wide_cmd_size_i     (wide_cmd_size_i),
    .wide_cmd_payload_i  (wide_cmd_payload_i),
    .wide_cmd_data_i     (wide_cmd_data_i),
    .wide_cmd_v_i        (wide_cmd_v_i),
    .wide_cmd_ready_o    (wide_cmd_ready_o),
    .wide_resp_write_o   (wide_resp_write_o),
    .wide_resp_addr_o    (wide_resp_addr_o),
    .wide_resp_size_o    (wide_resp_size_o),
    .wide_resp_payload_o (wide_resp_payload_o),
    .wide_resp_data_o    (wide_resp_data_o),
    .wide_resp_v_o       (wide_resp_v_o),
    .wide_resp_yumi_i    (wide_resp_yumi_i),
    .word_cmd_write_o    (word_cmd_write_o),
    .word_cmd_addr_o     (word_cmd_addr_o),
    .word_cmd_size_o     (word_cmd_size_o),
    .word_cmd_payload_o  (word_cmd_payload_o),
    .word_cmd_data_o     (word_cmd_data_o),
    .word_cmd_v_o        (word_cmd_v_o),
    .word_cmd_ready_i    (word_cmd_ready_i),
    .word_resp_data_i    (word_resp_data_i),
    .word_resp_v_i       (word_resp_v_i),
    .word_resp_yumi_o    (word_resp_yumi_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [39:0] a;
    logic [2:0]  s;
    logic [31:0] p;
    logic [31:0] d;
  } wcmd_t;

  typedef struct {
    int          due;
    logic [31:0] d;
  } wresp_t;

  int          total = 0;
  int          bad   = 0;
  wcmd_t       exp_q[$];
  wresp_t      rq[$];
  int          ncmds = 0;
  int          rcyc  = 0;
  int          lat   = 0;
  bit          rand_ready = 0;
  logic [31:0] salt  = 32'h0;
  bit          prev_stall = 0;
  logic [107:0] prev_fields;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream word memory: checks each word command against the expected
  // sequence and answers it in order after 'lat' cycles with addr ^ salt.
  always @(negedge clk) begin
    rcyc++;
    if (!reset_n) begin
      rq.delete();
      word_resp_v_i    = 1'b0;
      word_resp_data_i = '0;
      word_cmd_ready_i = 1'b0;
      prev_stall       = 1'b0;
    end else begin
      word_cmd_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rq.size() > 0 && rq[0].due <= rcyc) begin
        word_resp_v_i    = 1'b1;
        word_resp_data_i = rq[0].d;
      end else begin
        word_resp_v_i    = 1'b0;
        word_resp_data_i = $urandom;
      end
      #1;
      if (prev_stall) begin
        chk("stall_v", 512'(word_cmd_v_o), 512'd1);
        chk("stall_fields", 512'({word_cmd_write_o, word_cmd_addr_o, word_cmd_size_o,
                                  word_cmd_payload_o, word_cmd_data_o}), 512'(prev_fields));
      end
      if (word_cmd_v_o && word_cmd_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cmd", 512'd1, 512'd0);
        end else begin
          wcmd_t e;
          e = exp_q.pop_front();
          chk("cmd_write", 512'(word_cmd_write_o), 512'(e.w));
          chk("cmd_addr", 512'(word_cmd_addr_o), 512'(e.a));
          chk("cmd_size", 512'(word_cmd_size_o), 512'(e.s));
          chk("cmd_payload", 512'(word_cmd_payload_o), 512'(e.p));
          if (e.w) chk("cmd_data", 512'(word_cmd_data_o), 512'(e.d));
        end
        rq.push_back('{due: rcyc + 1 + lat, d: word_cmd_addr_o[31:0] ^ salt});
        ncmds++;
      end
      if (word_resp_yumi_o) begin
        chk("yumi_has_v", 512'(word_resp_v_i), 512'd1);
        if (rq.size() > 0) void'(rq.pop_front());
      end
      prev_stall  = word_cmd_v_o && !word_cmd_ready_i;
      prev_fields = {word_cmd_write_o, word_cmd_addr_o, word_cmd_size_o,
                     word_cmd_payload_o, word_cmd_data_o};
    end
  end

  // One full wide transaction: model, issue, wait, check, optional hold, retire
  task automatic run_txn(input bit w, input logic [39:0] a, input logic [2:0] s,
                         input logic [511:0] d, input int hold, input bit chk_lat);
    logic [511:0] exp_data;
    logic [31:0]  p;
    int           n;
    int           k;
    wcmd_t        e;
    p        = $urandom;
    n        = (s <= 3'd2) ? 1 : (1 << s) / 4;
    exp_data = '0;
    for (int i = 0; i < n; i++) begin
      e.w = w;
      e.a = a + 40'(4 * i);
      e.s = (s < 3'd2) ? s : 3'd2;
      e.p = p;
      e.d = d[32*i +: 32];
      exp_q.push_back(e);
      if (!w) exp_data[32*i +: 32] = e.a[31:0] ^ salt;
    end
    ncmds = 0;
    @(negedge clk);
    wide_cmd_v_i       = 1'b1;
    wide_cmd_write_i   = w;
    wide_cmd_addr_i    = a;
    wide_cmd_size_i    = s;
    wide_cmd_payload_i = p;
    wide_cmd_data_i    = d;
    #1;
    chk("accept_ready", 512'(wide_cmd_ready_o), 512'd1);
    @(negedge clk);
    wide_cmd_v_i       = 1'b0;
    wide_cmd_addr_i    = {8'h0, $urandom};
    wide_cmd_payload_i = $urandom;
    wide_cmd_data_i    = {16{$urandom}};
    k = 1;
    #1;
    while (!wide_resp_v_o && k < 2000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("resp_timeout", 512'(wide_resp_v_o), 512'd1);
    if (chk_lat) chk("resp_latency", 512'(k), 512'd3);
    chk("resp_write", 512'(wide_resp_write_o), 512'(w));
    chk("resp_addr", 512'(wide_resp_addr_o), 512'(a));
    chk("resp_size", 512'(wide_resp_size_o), 512'(s));
    chk("resp_payload", 512'(wide_resp_payload_o), 512'(p));
    chk("resp_data", wide_resp_data_o, exp_data);
    chk("beats_sent", 512'(ncmds), 512'(n));
    chk("beats_left", 512'(exp_q.size()), 512'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      chk("hold_v", 512'(wide_resp_v_o), 512'd1);
      chk("hold_data", wide_resp_data_o, exp_data);
      chk("hold_ready", 512'(wide_cmd_ready_o), 512'd0);
    end
    wide_resp_yumi_i = 1'b1;
    chk("yumi_cycle_ready", 512'(wide_cmd_ready_o), 512'd0);
    @(negedge clk);
    wide_resp_yumi_i = 1'b0;
    #1;
    chk("after_yumi_v", 512'(wide_resp_v_o), 512'd0);
    chk("after_yumi_ready", 512'(wide_cmd_ready_o), 512'd1);
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    logic [511:0] blk;
    logic [2:0]   rs;
    int           k;
    reset_n            = 1'b0;
    wide_cmd_v_i       = 1'b0;
    wide_cmd_write_i   = 1'b0;
    wide_cmd_addr_i    = '0;
    wide_cmd_size_i    = '0;
    wide_cmd_payload_i = '0;
    wide_cmd_data_i    = '0;
    wide_resp_yumi_i   = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_ready", 512'(wide_cmd_ready_o), 512'd0);
    chk("rst_word_v", 512'(word_cmd_v_o), 512'd0);
    chk("rst_resp_v", 512'(wide_resp_v_o), 512'd0);
    chk("rst_yumi", 512'(word_resp_yumi_o), 512'd0);
    chk("rst_data", wide_resp_data_o, 512'd0);
    @(negedge clk);
    #3;
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", 512'(wide_cmd_ready_o), 512'd1);

    // Block read, data equals address
    salt = 32'h0;
    lat  = 0;
    run_txn(1'b0, 40'h00_8000_0040, 3'd6, rand_block(), 0, 1'b0);

    // Two-word write
    salt = $urandom;
    blk  = rand_block();
    blk[63:0] = {32'h0000_BBBB, 32'h0000_AAAA};
    run_txn(1'b1, 40'h100, 3'd3, blk, 0, 1'b0);

    // Byte read, minimum latency
    run_txn(1'b0, 40'h103, 3'd0, rand_block(), 0, 1'b1);

    // Backpressure and delayed responses
    rand_ready = 1'b1;
    lat        = 5;
    salt       = $urandom;
    run_txn(1'b0, {8'h0, $urandom} & ~40'h3F, 3'd6, rand_block(), 0, 1'b0);
    run_txn(1'b1, {8'h0, $urandom} & ~40'h1F, 3'd5, rand_block(), 0, 1'b0);
    rand_ready = 1'b0;
    lat        = 0;

    // Upstream holds the response
    run_txn(1'b0, 40'h2340, 3'd4, rand_block(), 10, 1'b0);

    // Reset in the middle of a block read
    lat   = 2;
    ncmds = 0;
    @(negedge clk);
    wide_cmd_v_i     = 1'b1;
    wide_cmd_write_i = 1'b0;
    wide_cmd_addr_i  = 40'h4000;
    wide_cmd_size_i  = 3'd6;
    for (int i = 0; i < 16; i++) exp_q.push_back('{w: 1'b0, a: 40'h4000 + 40'(4 * i), s: 3'd2,
                                                   p: wide_cmd_payload_i, d: 32'h0});
    @(negedge clk);
    wide_cmd_v_i = 1'b0;
    k = 0;
    while (ncmds < 4 && k < 200) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk("mid_progress", 512'(ncmds >= 4), 512'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_word_v", 512'(word_cmd_v_o), 512'd0);
    chk("mid_rst_ready", 512'(wide_cmd_ready_o), 512'd0);
    chk("mid_rst_resp_v", 512'(wide_resp_v_o), 512'd0);
    chk("mid_rst_yumi", 512'(word_resp_yumi_o), 512'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #3;
    reset_n = 1'b1;
    #1;
    chk("mid_rel_ready", 512'(wide_cmd_ready_o), 512'd1);
    chk("mid_rel_resp_v", 512'(wide_resp_v_o), 512'd0);
    lat = 0;
    run_txn(1'b0, 40'h5000, 3'd6, rand_block(), 0, 1'b0);

    // Random mix
    for (int t = 0; t < 8; t++) begin
      rand_ready = 1'($urandom_range(0, 1));
      lat        = $urandom_range(0, 4);
      salt       = $urandom;
      rs         = 3'($urandom_range(0, 6));
      run_txn(1'($urandom_range(0, 1)), {8'h0, $urandom} & ~((40'd1 << rs) - 40'd1),
              rs, rand_block(), $urandom_range(0, 2), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
